// File: rtl/execute_pkg.sv
// Shared execute-stage types: ALU opcodes, ARM condition codes, NZCV bit positions.
package execute_pkg;

    localparam int unsigned NZCV_W = 4;
    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_ORR = 2'b11
    } alu_op_e;

    typedef enum logic [3:0] {
        COND_EQ = 4'h0,
        COND_NE = 4'h1,
        COND_CS = 4'h2,
        COND_CC = 4'h3,
        COND_MI = 4'h4,
        COND_PL = 4'h5,
        COND_VS = 4'h6,
        COND_VC = 4'h7,
        COND_HI = 4'h8,
        COND_LS = 4'h9,
        COND_GE = 4'hA,
        COND_LT = 4'hB,
        COND_GT = 4'hC,
        COND_LE = 4'hD,
        COND_AL = 4'hE,
        COND_NV = 4'hF
    } cond_e;

    // Memory-stage control bundle carried across the EX/MEM register
    typedef struct packed {
        logic pcsrc;
        logic regwrite;
        logic memtoreg;
        logic memwrite;
    } mem_ctrl_t;

    // ARM condition evaluation against the current NZCV value
    function automatic logic cond_holds(input cond_e cond, input logic [NZCV_W-1:0] f);
        logic n;
        logic z;
        logic c;
        logic v;
        logic res;
        n   = f[FLAG_N];
        z   = f[FLAG_Z];
        c   = f[FLAG_C];
        v   = f[FLAG_V];
        res = 1'b0;
        case (cond)
            COND_EQ: res = z;
            COND_NE: res = ~z;
            COND_CS: res = c;
            COND_CC: res = ~c;
            COND_MI: res = n;
            COND_PL: res = ~n;
            COND_VS: res = v;
            COND_VC: res = ~v;
            COND_HI: res = c & ~z;
            COND_LS: res = ~c | z;
            COND_GE: res = (n == v);
            COND_LT: res = (n != v);
            COND_GT: res = ~z & (n == v);
            COND_LE: res = z | (n != v);
            COND_AL: res = 1'b1;
            COND_NV: res = 1'b0;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/execute_stage_if.sv
// Execute-stage inputs and EX/MEM outputs bundled for the pipeline datapath.
interface execute_stage_if #(
    parameter int unsigned WIDTH = 32
);
    logic             PCSrcE;
    logic             RegWriteE;
    logic             MemtoRegE;
    logic             MemWriteE;
    logic [1:0]       ALUControlE;
    logic             BranchE;
    logic             ALUSrcE;
    logic [1:0]       FlagWriteE;
    logic [3:0]       CondE;
    logic [WIDTH-1:0] SrcAE;
    logic [WIDTH-1:0] WriteDataE;
    logic [3:0]       WA3E;
    logic [WIDTH-1:0] ExtImmE;

    logic             BranchTakenE;
    logic [WIDTH-1:0] ALUResultE;
    logic             PCSrcM;
    logic             RegWriteM;
    logic             MemtoRegM;
    logic             MemWriteM;
    logic [WIDTH-1:0] ALUOutM;
    logic [WIDTH-1:0] WriteDataM;
    logic [3:0]       WA3M;
    logic [3:0]       FlagsQ;

    modport master (
        output PCSrcE, RegWriteE, MemtoRegE, MemWriteE, ALUControlE, BranchE,
               ALUSrcE, FlagWriteE, CondE, SrcAE, WriteDataE, WA3E, ExtImmE,
        input  BranchTakenE, ALUResultE, PCSrcM, RegWriteM, MemtoRegM, MemWriteM,
               ALUOutM, WriteDataM, WA3M, FlagsQ
    );

    modport slave (
        input  PCSrcE, RegWriteE, MemtoRegE, MemWriteE, ALUControlE, BranchE,
               ALUSrcE, FlagWriteE, CondE, SrcAE, WriteDataE, WA3E, ExtImmE,
        output BranchTakenE, ALUResultE, PCSrcM, RegWriteM, MemtoRegM, MemWriteM,
               ALUOutM, WriteDataM, WA3M, FlagsQ
    );
endinterface

// File: rtl/execute_stage_alu.sv
// Two-operand ALU: ADD/SUB/AND/ORR with NZCV generation.
module alu
    import execute_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  alu_op_e           op,
    output logic [WIDTH-1:0]  result,
    output logic [NZCV_W-1:0] nzcv
);

    logic             is_sub;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;

    // Shared adder; subtraction is a + ~b + 1 so carry-out means "no borrow"
    always_comb begin
        is_sub = (op == ALU_SUB);
        b_eff  = is_sub ? ~b : b;
        sum    = {1'b0, a} + {1'b0, b_eff} + (WIDTH + 1)'(is_sub);
        result = '0;
        nzcv   = '0;
        case (op)
            ALU_ADD, ALU_SUB: begin
                result       = sum[WIDTH-1:0];
                nzcv[FLAG_C] = sum[WIDTH];
                nzcv[FLAG_V] = (a[WIDTH-1] == b_eff[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_AND: result = a & b;
            ALU_ORR: result = a | b;
            default: result = '0;
        endcase
        nzcv[FLAG_N] = result[WIDTH-1];
        nzcv[FLAG_Z] = (result == '0);
    end

endmodule

// File: rtl/execute_stage.sv
// Execute stage: ALU, condition check, flag register and EX/MEM pipeline register.
module execute_stage
    import execute_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            StallM,
    input  logic            FlushM,
    execute_stage_if.slave  bus
);

    logic [WIDTH-1:0]  src_b;
    logic [WIDTH-1:0]  alu_result;
    logic [NZCV_W-1:0] alu_nzcv;
    logic [NZCV_W-1:0] flags_next;
    logic              cond_ex;
    mem_ctrl_t         ctrl_next;
    mem_ctrl_t         ctrl_q;

    alu #(.WIDTH(WIDTH)) u_alu (
        .a      (bus.SrcAE),
        .b      (src_b),
        .op     (alu_op_e'(bus.ALUControlE)),
        .result (alu_result),
        .nzcv   (alu_nzcv)
    );

    // Operand select, condition evaluation on pre-update flags, gated controls and next flags
    always_comb begin
        src_b   = bus.ALUSrcE ? bus.ExtImmE : bus.WriteDataE;
        cond_ex = cond_holds(cond_e'(bus.CondE), bus.FlagsQ);

        ctrl_next.pcsrc    = bus.PCSrcE & cond_ex;
        ctrl_next.regwrite = bus.RegWriteE & cond_ex;
        ctrl_next.memtoreg = bus.MemtoRegE;
        ctrl_next.memwrite = bus.MemWriteE & cond_ex;

        flags_next = bus.FlagsQ;
        if (bus.FlagWriteE[1] && cond_ex) begin
            flags_next[FLAG_N] = alu_nzcv[FLAG_N];
            flags_next[FLAG_Z] = alu_nzcv[FLAG_Z];
        end
        if (bus.FlagWriteE[0] && cond_ex) begin
            flags_next[FLAG_C] = alu_nzcv[FLAG_C];
            flags_next[FLAG_V] = alu_nzcv[FLAG_V];
        end
    end

    assign bus.BranchTakenE = bus.BranchE & cond_ex & ~FlushM;
    assign bus.ALUResultE   = alu_result;

    // EX/MEM register: flush inserts a bubble and overrides stall
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_q         <= '0;
            bus.ALUOutM    <= '0;
            bus.WriteDataM <= '0;
            bus.WA3M       <= '0;
        end else if (FlushM) begin
            ctrl_q         <= '0;
            bus.ALUOutM    <= '0;
            bus.WriteDataM <= '0;
            bus.WA3M       <= '0;
        end else if (!StallM) begin
            ctrl_q         <= ctrl_next;
            bus.ALUOutM    <= alu_result;
            bus.WriteDataM <= bus.WriteDataE;
            bus.WA3M       <= bus.WA3E;
        end
    end

    // NZCV register: only a live, unstalled instruction may update it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.FlagsQ <= '0;
        end else if (!StallM && !FlushM) begin
            bus.FlagsQ <= flags_next;
        end
    end

    assign bus.PCSrcM    = ctrl_q.pcsrc;
    assign bus.RegWriteM = ctrl_q.regwrite;
    assign bus.MemtoRegM = ctrl_q.memtoreg;
    assign bus.MemWriteM = ctrl_q.memwrite;

endmodule

// File: tb/tb_execute_stage.sv
// Directed vector bench for execute_stage.
module tb_execute_stage;

    logic clk;
    logic reset;
    logic StallM;
    logic FlushM;

    execute_stage_if #(.WIDTH(32)) bus ();

    execute_stage #(.WIDTH(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .StallM (StallM),
        .FlushM (FlushM),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        flush;
        logic        pcsrc;
        logic        regw;
        logic        memtoreg;
        logic        memw;
        logic [1:0]  aluctl;
        logic        branch;
        logic        alusrc;
        logic [1:0]  fw;
        logic [3:0]  cond;
        logic [31:0] srca;
        logic [31:0] wdata;
        logic [3:0]  wa3;
        logic [31:0] imm;
        logic        exp_bt;
        logic [31:0] exp_res;
        logic [3:0]  exp_ctl;
        logic [3:0]  exp_flags;
    } vec_t;

    localparam int unsigned NVEC = 15;
    vec_t vecs[NVEC];

    int vectors;
    int miscompares;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        StallM          = v.stall;
        FlushM          = v.flush;
        bus.PCSrcE      = v.pcsrc;
        bus.RegWriteE   = v.regw;
        bus.MemtoRegE   = v.memtoreg;
        bus.MemWriteE   = v.memw;
        bus.ALUControlE = v.aluctl;
        bus.BranchE     = v.branch;
        bus.ALUSrcE     = v.alusrc;
        bus.FlagWriteE  = v.fw;
        bus.CondE       = v.cond;
        bus.SrcAE       = v.srca;
        bus.WriteDataE  = v.wdata;
        bus.WA3E        = v.wa3;
        bus.ExtImmE     = v.imm;
    endtask

    function automatic logic [3:0] mctl();
        return {bus.PCSrcM, bus.RegWriteM, bus.MemtoRegM, bus.MemWriteM};
    endfunction

    task automatic check_m(input string tag, input logic [3:0] ctl, input logic [31:0] aluout,
                           input logic [31:0] wd, input logic [3:0] wa3, input logic [3:0] flags);
        check({tag, ".ctl"},    32'(mctl()),         32'(ctl));
        check({tag, ".aluout"}, bus.ALUOutM,         aluout);
        check({tag, ".wd"},     bus.WriteDataM,      wd);
        check({tag, ".wa3"},    32'(bus.WA3M),       32'(wa3));
        check({tag, ".flags"},  32'(bus.FlagsQ),     32'(flags));
    endtask

    initial begin
        vec_t v;
        vectors     = 0;
        miscompares = 0;

        // stall flush pc rw m2r mw ctl br src fw cond srca wdata wa3 imm | bt res ctl flags
        vecs[0]  = '{1'b0,1'b0, 1'b0,1'b1,1'b0,1'b0, 2'b00, 1'b0,1'b1, 2'b11, 4'hE, 32'h7FFFFFFF, 32'h11, 4'h3, 32'h1,
                     1'b0, 32'h80000000, 4'b0100, 4'b1001};
        vecs[1]  = '{1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0, 2'b01, 1'b0,1'b0, 2'b11, 4'hE, 32'h5, 32'h5, 4'h0, 32'h0,
                     1'b0, 32'h0, 4'b0000, 4'b0110};
        vecs[2]  = '{1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0, 2'b00, 1'b1,1'b1, 2'b00, 4'h0, 32'h100, 32'h0, 4'h0, 32'h20,
                     1'b1, 32'h120, 4'b1000, 4'b0110};
        vecs[3]  = '{1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0, 2'b00, 1'b1,1'b1, 2'b00, 4'h1, 32'h100, 32'h0, 4'h0, 32'h20,
                     1'b0, 32'h120, 4'b0000, 4'b0110};
        vecs[4]  = '{1'b0,1'b0, 1'b0,1'b1,1'b0,1'b0, 2'b11, 1'b0,1'b0, 2'b10, 4'hE, 32'hF0, 32'h0F, 4'h5, 32'h0,
                     1'b0, 32'hFF, 4'b0100, 4'b0010};
        vecs[5]  = '{1'b0,1'b0, 1'b0,1'b1,1'b1,1'b1, 2'b00, 1'b0,1'b1, 2'b11, 4'h0, 32'h1, 32'hAA, 4'h7, 32'h1,
                     1'b0, 32'h2, 4'b0010, 4'b0010};
        vecs[6]  = '{1'b0,1'b0, 1'b1,1'b1,1'b0,1'b1, 2'b01, 1'b0,1'b0, 2'b11, 4'hF, 32'h3, 32'h7, 4'h1, 32'h0,
                     1'b0, 32'hFFFFFFFC, 4'b0000, 4'b0010};
        vecs[7]  = '{1'b0,1'b0, 1'b0,1'b1,1'b0,1'b0, 2'b10, 1'b0,1'b0, 2'b11, 4'hE, 32'hF0F0F0F0, 32'h0F0F0F0F, 4'h2, 32'h0,
                     1'b0, 32'h0, 4'b0100, 4'b0100};
        vecs[8]  = '{1'b0,1'b0, 1'b0,1'b1,1'b0,1'b0, 2'b00, 1'b1,1'b1, 2'b00, 4'hC, 32'h0, 32'h0, 4'h0, 32'h0,
                     1'b0, 32'h0, 4'b0000, 4'b0100};
        vecs[9]  = '{1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0, 2'b00, 1'b1,1'b1, 2'b00, 4'hD, 32'h1000, 32'h0, 4'h0, 32'h4,
                     1'b1, 32'h1004, 4'b1000, 4'b0100};
        vecs[10] = '{1'b0,1'b0, 1'b0,1'b1,1'b0,1'b0, 2'b01, 1'b0,1'b0, 2'b11, 4'hE, 32'h3, 32'h5, 4'h9, 32'h0,
                     1'b0, 32'hFFFFFFFE, 4'b0100, 4'b1000};
        vecs[11] = '{1'b0,1'b0, 1'b0,1'b0,1'b0,1'b1, 2'b00, 1'b1,1'b1, 2'b00, 4'hB, 32'h8, 32'h0, 4'h0, 32'h8,
                     1'b1, 32'h10, 4'b0001, 4'b1000};
        vecs[12] = '{1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0, 2'b00, 1'b1,1'b1, 2'b00, 4'hA, 32'h8, 32'h0, 4'h0, 32'h8,
                     1'b0, 32'h10, 4'b0000, 4'b1000};
        vecs[13] = '{1'b0,1'b0, 1'b0,1'b1,1'b0,1'b0, 2'b00, 1'b0,1'b1, 2'b10, 4'h8, 32'h0, 32'h0, 4'h6, 32'h0,
                     1'b0, 32'h0, 4'b0000, 4'b1000};
        vecs[14] = '{1'b0,1'b1, 1'b0,1'b1,1'b0,1'b0, 2'b00, 1'b1,1'b1, 2'b11, 4'hE, 32'h1, 32'h0, 4'h0, 32'h1,
                     1'b0, 32'h2, 4'b0000, 4'b1000};

        // Reset state
        reset = 1'b1;
        v = vecs[1];
        drive(v);
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        check_m("reset", 4'b0000, 32'h0, 32'h0, 4'h0, 4'h0);
        @(negedge clk);
        reset = 1'b0;

        // Table: combinational outputs before the edge, registered outputs after it
        for (int i = 0; i < int'(NVEC); i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            @(negedge clk);
            drive(vecs[i]);
            #1;
            vectors++;
            check({tag, ".bt"},  32'(bus.BranchTakenE), 32'(vecs[i].exp_bt));
            check({tag, ".res"}, bus.ALUResultE,        vecs[i].exp_res);
            @(posedge clk);
            #1;
            check_m(tag, vecs[i].exp_ctl,
                    vecs[i].flush ? 32'h0 : vecs[i].exp_res,
                    vecs[i].flush ? 32'h0 : vecs[i].wdata,
                    vecs[i].flush ? 4'h0  : vecs[i].wa3,
                    vecs[i].exp_flags);
        end

        // Stall: capture one instruction, then hold it for two cycles of changing inputs
        @(negedge clk);
        v = '{1'b0,1'b0, 1'b0,1'b1,1'b0,1'b0, 2'b00, 1'b0,1'b1, 2'b11, 4'hE, 32'h55, 32'h66, 4'h4, 32'h0,
              1'b0, 32'h55, 4'b0100, 4'b0000};
        drive(v);
        @(posedge clk);
        #1;
        vectors++;
        check_m("stall_pre", 4'b0100, 32'h55, 32'h66, 4'h4, 4'b0000);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            v.stall  = 1'b1;
            v.aluctl = 2'b01;
            v.alusrc = 1'b0;
            v.srca   = 32'(k);
            v.wdata  = 32'h1 + 32'(k);
            v.memw   = 1'b1;
            v.wa3    = 4'hA;
            drive(v);
            @(posedge clk);
            #1;
            vectors++;
            check_m($sformatf("stall%0d", k), 4'b0100, 32'h55, 32'h66, 4'h4, 4'b0000);
        end
        @(negedge clk);
        v.flush = 1'b1;
        drive(v);
        @(posedge clk);
        #1;
        vectors++;
        check_m("stall_flush", 4'b0000, 32'h0, 32'h0, 4'h0, 4'b0000);

        // Asynchronous reset mid-cycle, then resume on the next edge
        @(negedge clk);
        v = vecs[0];
        drive(v);
        @(posedge clk);
        #1;
        vectors++;
        check_m("prerst", 4'b0100, 32'h80000000, 32'h11, 4'h3, 4'b1001);
        #2;
        reset = 1'b1;
        #1;
        vectors++;
        check_m("midrst", 4'b0000, 32'h0, 32'h0, 4'h0, 4'b0000);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        vectors++;
        check_m("postrst", 4'b0100, 32'h80000000, 32'h11, 4'h3, 4'b1001);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
